// File: rtl/header_seq_pkg.sv
// Shared types and width helpers for the header stream sequencer.
package header_seq_pkg;

  // Sequencer states; exported on the debug port of the top module.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ALIGN  = 3'd2,
    KICK   = 3'd3,
    STREAM = 3'd4,
    FINAL  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // The source index must be able to step one past the last source.
  function automatic int idx_width(input int n_src);
    return $clog2(n_src + 1);
  endfunction

  // Bit counter carries byte offset plus three sub-byte bits.
  function automatic int cnt_width(input int off_w);
    return off_w + 3;
  endfunction

endpackage

// File: rtl/header_stream_sequencer_if.sv
// Chunk/flush channel toward the set_bit writer.
//
// Handshake: a beat is present while sb_enable (data chunk) or sb_flush
// (pad to byte boundary) is high; the two are never high together. The beat
// transfers on a rising clock edge where it is present and sb_ready is high.
// While present and sb_ready is low, every sb_* field holds its value.
interface header_stream_sequencer_if #(
  parameter int VAL_W  = 64,
  parameter int BITS_W = 64
);
  logic              sb_enable;
  logic [VAL_W-1:0]  sb_val;
  logic [BITS_W-1:0] sb_size_of_bit;
  logic              sb_flush;
  logic              sb_ready;

  modport master (
    output sb_enable,
    output sb_val,
    output sb_size_of_bit,
    output sb_flush,
    input  sb_ready
  );

  modport slave (
    input  sb_enable,
    input  sb_val,
    input  sb_size_of_bit,
    input  sb_flush,
    output sb_ready
  );
endinterface

// File: rtl/header_stream_sequencer_src_mux.sv
// N-to-1 selection of the active generator's chunk fields, plus ready fan-out
// so that only the selected generator can ever see ready.
module header_src_mux
  import header_seq_pkg::*;
#(
  parameter int N_SRC  = 5,
  parameter int VAL_W  = 64,
  parameter int BITS_W = 64,
  parameter int IDX_W  = idx_width(N_SRC)
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic                    ready_in,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*VAL_W-1:0]  src_val,
  input  logic [N_SRC*BITS_W-1:0] src_bits,
  input  logic [N_SRC-1:0]        src_last,
  output logic                    sel_valid,
  output logic [VAL_W-1:0]        sel_val,
  output logic [BITS_W-1:0]       sel_bits,
  output logic                    sel_last,
  output logic [N_SRC-1:0]        src_ready
);

  // Pick the fields of source idx; an out-of-range idx selects nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_val   = '0;
    sel_bits  = '0;
    sel_last  = 1'b0;
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_valid    = src_valid[i];
        sel_val      = src_val[i*VAL_W +: VAL_W];
        sel_bits     = src_bits[i*BITS_W +: BITS_W];
        sel_last     = src_last[i];
        src_ready[i] = ready_in;
      end
    end
  end

endmodule

// File: rtl/header_stream_sequencer.sv
// Runs the header generators in index order, forwards their chunks through a
// single registered output stage toward set_bit, byte-aligns selected
// sources and records each source's starting byte offset.
module header_stream_sequencer
  import header_seq_pkg::*;
#(
  parameter int               N_SRC      = 5,
  parameter int               VAL_W      = 64,
  parameter int               BITS_W     = 64,
  parameter int               OFF_W      = 32,
  parameter logic [N_SRC-1:0] ALIGN_MASK = 'b00100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N_SRC-1:0]        src_en,
  output logic [N_SRC-1:0]        src_start,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*VAL_W-1:0]  src_val,
  input  logic [N_SRC*BITS_W-1:0] src_bits,
  input  logic [N_SRC-1:0]        src_last,
  output logic [N_SRC-1:0]        src_ready,
  header_stream_sequencer_if.master sb,
  output logic                    busy,
  output logic                    done,
  output logic [N_SRC*OFF_W-1:0]  src_offset,
  output logic [OFF_W-1:0]        total_bytes,
  output logic                    err,
  output state_t                  dbg_state
);

  localparam int IDX_W = idx_width(N_SRC);
  localparam int CNT_W = cnt_width(OFF_W);
  localparam logic [BITS_W-1:0] BITS_MAX = BITS_W'(VAL_W);

  state_t             state, next_state;
  logic [IDX_W-1:0]   idx;
  logic [N_SRC-1:0]   en_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_rounded;
  logic [OFF_W-1:0]   offset_q [N_SRC];
  logic [OFF_W-1:0]   total_q;
  logic               err_q;

  // Output register: one beat, either a data chunk or a flush.
  logic               out_vld;
  logic               out_flush;
  logic [VAL_W-1:0]   out_val;
  logic [BITS_W-1:0]  out_bits;

  logic               cur_valid, cur_last;
  logic [VAL_W-1:0]   cur_val;
  logic [BITS_W-1:0]  cur_bits, bits_eff;
  logic               clamp_hit;
  logic               slot_free, stream_en, accept;
  logic               cnt_unaligned;
  logic               found, pick_align;
  logic [IDX_W-1:0]   pick;

  header_src_mux #(
    .N_SRC  (N_SRC),
    .VAL_W  (VAL_W),
    .BITS_W (BITS_W),
    .IDX_W  (IDX_W)
  ) u_mux (
    .idx       (idx),
    .ready_in  (stream_en),
    .src_valid (src_valid),
    .src_val   (src_val),
    .src_bits  (src_bits),
    .src_last  (src_last),
    .sel_valid (cur_valid),
    .sel_val   (cur_val),
    .sel_bits  (cur_bits),
    .sel_last  (cur_last),
    .src_ready (src_ready)
  );

  // The output slot can take a new beat if empty or being drained this edge.
  assign slot_free     = !out_vld || sb.sb_ready;
  assign stream_en     = (state == STREAM) && slot_free;
  assign accept        = stream_en && cur_valid;
  assign clamp_hit     = cur_bits > BITS_MAX;
  assign bits_eff      = clamp_hit ? BITS_MAX : cur_bits;
  assign cnt_unaligned = bit_cnt[2:0] != 3'd0;
  assign cnt_rounded   = {bit_cnt[CNT_W-1:3] + OFF_W'(1), 3'b000};

  // Lowest enabled source at or above idx; scanning downward lets the lowest win.
  always_comb begin
    found      = 1'b0;
    pick       = idx;
    pick_align = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (en_q[i] && (IDX_W'(i) >= idx)) begin
        found      = 1'b1;
        pick       = IDX_W'(i);
        pick_align = ALIGN_MASK[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = SELECT;
      SELECT: begin
        if (!found)                          next_state = FINAL;
        else if (pick_align && cnt_unaligned) next_state = ALIGN;
        else                                  next_state = KICK;
      end
      ALIGN:  if (slot_free) next_state = KICK;
      KICK:   next_state = STREAM;
      STREAM: if (accept && cur_last) next_state = SELECT;
      FINAL:  if (!out_vld && !cnt_unaligned) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: counters, offset table, error flag and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      en_q      <= '0;
      bit_cnt   <= '0;
      total_q   <= '0;
      err_q     <= 1'b0;
      out_vld   <= 1'b0;
      out_flush <= 1'b0;
      out_val   <= '0;
      out_bits  <= '0;
      for (int i = 0; i < N_SRC; i++) offset_q[i] <= '0;
    end else begin
      if (out_vld && sb.sb_ready) out_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            en_q    <= src_en;
            idx     <= '0;
            bit_cnt <= '0;
            err_q   <= 1'b0;
            total_q <= '0;
          end
        end
        SELECT: begin
          if (found) idx <= pick;
        end
        ALIGN: begin
          if (slot_free) begin
            out_vld   <= 1'b1;
            out_flush <= 1'b1;
            out_val   <= '0;
            out_bits  <= '0;
            bit_cnt   <= cnt_rounded;
          end
        end
        KICK: begin
          for (int i = 0; i < N_SRC; i++)
            if (idx == IDX_W'(i)) offset_q[i] <= bit_cnt[CNT_W-1:3];
        end
        STREAM: begin
          if (accept) begin
            bit_cnt <= bit_cnt + CNT_W'(bits_eff);
            if (clamp_hit) err_q <= 1'b1;
            // Zero-length chunks advance the source but produce no beat.
            if (bits_eff != '0) begin
              out_vld   <= 1'b1;
              out_flush <= 1'b0;
              out_val   <= cur_val;
              out_bits  <= bits_eff;
            end
            if (cur_last) idx <= idx + IDX_W'(1);
          end
        end
        FINAL: begin
          if (!out_vld) begin
            if (cnt_unaligned) begin
              out_vld   <= 1'b1;
              out_flush <= 1'b1;
              out_val   <= '0;
              out_bits  <= '0;
              bit_cnt   <= cnt_rounded;
            end else begin
              total_q <= bit_cnt[CNT_W-1:3];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot kick toward the selected generator.
  always_comb begin
    src_start = '0;
    for (int i = 0; i < N_SRC; i++)
      if ((state == KICK) && (idx == IDX_W'(i))) src_start[i] = 1'b1;
  end

  // Flatten the offset table onto the output bus.
  always_comb begin
    src_offset = '0;
    for (int i = 0; i < N_SRC; i++) src_offset[i*OFF_W +: OFF_W] = offset_q[i];
  end

  assign sb.sb_enable      = out_vld && !out_flush;
  assign sb.sb_flush       = out_vld && out_flush;
  assign sb.sb_val         = out_val;
  assign sb.sb_size_of_bit = out_bits;

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign total_bytes = total_q;
  assign err         = err_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_header_stream_sequencer.sv
// Bench for header_stream_sequencer: directed and random runs checked against
// a byte/bit accounting model of the run.
module tb_header_stream_sequencer;
  import header_seq_pkg::*;

  localparam int N_SRC  = 5;
  localparam int VAL_W  = 64;
  localparam int BITS_W = 64;
  localparam int OFF_W  = 32;
  localparam logic [N_SRC-1:0] ALIGN_MASK = 5'b00100;
  localparam int BEAT_W = 1 + VAL_W + BITS_W;
  localparam int CW     = 192;
  localparam int MAX_CH = 6;
  localparam logic [BEAT_W-1:0] FLUSH_BEAT = {1'b1, {(BEAT_W-1){1'b0}}};

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                    start = 1'b0;
  logic [N_SRC-1:0]        src_en = '0;
  logic [N_SRC-1:0]        src_start;
  logic [N_SRC-1:0]        src_valid = '0;
  logic [N_SRC*VAL_W-1:0]  src_val = '0;
  logic [N_SRC*BITS_W-1:0] src_bits = '0;
  logic [N_SRC-1:0]        src_last = '0;
  logic [N_SRC-1:0]        src_ready;
  logic                    busy, done, err;
  logic [N_SRC*OFF_W-1:0]  src_offset;
  logic [OFF_W-1:0]        total_bytes;
  state_t                  dbg_state;
  logic                    sb_ready;

  header_stream_sequencer_if #(.VAL_W(VAL_W), .BITS_W(BITS_W)) sb ();
  assign sb.sb_ready = sb_ready;

  header_stream_sequencer #(
    .N_SRC(N_SRC), .VAL_W(VAL_W), .BITS_W(BITS_W), .OFF_W(OFF_W), .ALIGN_MASK(ALIGN_MASK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .src_en      (src_en),
    .src_start   (src_start),
    .src_valid   (src_valid),
    .src_val     (src_val),
    .src_bits    (src_bits),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .sb          (sb.master),
    .busy        (busy),
    .done        (done),
    .src_offset  (src_offset),
    .total_bytes (total_bytes),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- stimulus storage and model ----------------
  logic [N_SRC-1:0]  run_en;
  int                nch [N_SRC];
  logic [VAL_W-1:0]  ch_val  [N_SRC][MAX_CH];
  logic [BITS_W-1:0] ch_bits [N_SRC][MAX_CH];

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] obs_q[$];
  logic [OFF_W-1:0]  exp_off [N_SRC];
  logic [OFF_W-1:0]  exp_total;
  logic              exp_err;

  int rdy_mode = 0;
  int rdy_phase = 0;
  bit gap_on = 0;
  bit junk_on = 0;

  task automatic clear_stim();
    run_en = '0;
    for (int s = 0; s < N_SRC; s++) nch[s] = 0;
  endtask

  task automatic add_chunk(input int s, input int b);
    logic [VAL_W-1:0] v;
    v = {$urandom, $urandom};
    if (b < VAL_W) v = v & ((64'd1 << b) - 64'd1);
    ch_val[s][nch[s]]  = v;
    ch_bits[s][nch[s]] = BITS_W'(b);
    nch[s]++;
    run_en[s] = 1'b1;
  endtask

  task automatic load_t1();
    clear_stim();
    repeat (3) add_chunk(0, 32);
    add_chunk(1, 8);
    repeat (2) add_chunk(2, 16);
    add_chunk(3, 4);
    add_chunk(4, 12);
  endtask

  // Bit-level accounting of a run: where each source starts, which beats
  // reach set_bit, and the padded frame length.
  task automatic build_expected();
    longint unsigned nbits;
    longint unsigned b;
    nbits = 0;
    exp_err = 1'b0;
    exp_q.delete();
    for (int s = 0; s < N_SRC; s++) begin
      exp_off[s] = '0;
      if (run_en[s]) begin
        if (ALIGN_MASK[s] && (nbits % 8 != 0)) begin
          exp_q.push_back(FLUSH_BEAT);
          nbits = (nbits + 7) / 8 * 8;
        end
        exp_off[s] = OFF_W'(nbits / 8);
        for (int j = 0; j < nch[s]; j++) begin
          b = ch_bits[s][j];
          if (b > VAL_W) begin
            exp_err = 1'b1;
            b = VAL_W;
          end
          if (b != 0) exp_q.push_back({1'b0, ch_val[s][j], BITS_W'(b)});
          nbits += b;
        end
      end
    end
    if (nbits % 8 != 0) begin
      exp_q.push_back(FLUSH_BEAT);
      nbits = (nbits + 7) / 8 * 8;
    end
    exp_total = OFF_W'(nbits / 8);
  endtask

  // ---------------- set_bit side: ready driver and beat monitor ----------------
  initial begin
    sb_ready = 1'b1;
    forever begin
      @(negedge clock);
      case (rdy_mode)
        1:       sb_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
        2:       sb_ready = 1'($urandom_range(0, 1));
        default: sb_ready = 1'b1;
      endcase
      rdy_phase++;
    end
  end

  initial begin : beat_monitor
    logic [CW-1:0] prev_v;
    logic [CW-1:0] now_v;
    bit prev_held;
    prev_held = 0;
    prev_v = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) prev_held = 0;
      else begin
        now_v = CW'({sb.sb_enable, sb.sb_flush, sb.sb_val, sb.sb_size_of_bit});
        check("beat_excl", CW'(sb.sb_enable & sb.sb_flush), '0);
        if (prev_held) check("beat_hold", now_v, prev_v);
        if ((sb.sb_enable || sb.sb_flush) && sb_ready)
          obs_q.push_back(sb.sb_flush ? FLUSH_BEAT : {1'b0, sb.sb_val, sb.sb_size_of_bit});
        prev_held = (sb.sb_enable || sb.sb_flush) && !sb_ready;
        prev_v = now_v;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_source(input int s, input bit abort, output bit aborted);
    logic [N_SRC-1:0] me;
    int cnt;
    bit acc, go;
    me = N_SRC'(1) << s;
    aborted = 0;
    cnt = 0;
    do begin
      @(negedge clock);
      #1;
      cnt++;
    end while ((src_start == '0) && (cnt < 200));
    check("kick", src_start, me);
    for (int j = 0; j < nch[s]; j++) begin
      acc = 0;
      cnt = 0;
      while (!acc && (cnt < 200)) begin
        @(negedge clock);
        go = gap_on ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (junk_on) begin
          src_valid = N_SRC'($urandom);
          src_last  = N_SRC'($urandom);
          for (int k = 0; k < N_SRC; k++) begin
            src_val[k*VAL_W +: VAL_W]    = {$urandom, $urandom};
            src_bits[k*BITS_W +: BITS_W] = BITS_W'($urandom_range(0, 64));
          end
        end else begin
          src_valid = '0;
          src_last  = '0;
        end
        src_valid[s] = go;
        src_last[s]  = (j == nch[s] - 1);
        src_val[s*VAL_W +: VAL_W]    = ch_val[s][j];
        src_bits[s*BITS_W +: BITS_W] = ch_bits[s][j];
        #1;
        cnt++;
        check("ready_scope", src_ready & ~me, '0);
        acc = go && src_ready[s];
      end
      if (!acc) begin
        check("accept_timeout", 0, 1);
        return;
      end
      if (abort) begin
        aborted = 1;
        return;
      end
    end
    @(negedge clock);
    src_valid = '0;
    src_last  = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_src_start"}, src_start, '0);
    check({tag, "_src_ready"}, src_ready, '0);
    check({tag, "_sb_enable"}, sb.sb_enable, '0);
    check({tag, "_sb_flush"}, sb.sb_flush, '0);
    check({tag, "_sb_val"}, sb.sb_val, '0);
    check({tag, "_sb_size"}, sb.sb_size_of_bit, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_done"}, done, '0);
    check({tag, "_offsets"}, src_offset, '0);
    check({tag, "_total"}, total_bytes, '0);
    check({tag, "_err"}, err, '0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // One complete run; abort_src >= 0 abandons the run inside that source.
  task automatic run_case(input int mode, input int abort_src, output bit aborted);
    int lat;
    int n;
    bit ab;
    aborted = 0;
    rdy_mode = mode;
    gap_on  = (mode != 0);
    junk_on = (mode == 2);
    build_expected();
    obs_q.delete();
    @(negedge clock);
    start  = 1'b1;
    src_en = run_en;
    @(negedge clock);
    start = 1'b0;
    src_en = N_SRC'($urandom);
    #1;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    lat = 1;
    for (int s = 0; s < N_SRC; s++) begin
      if (run_en[s]) begin
        drive_source(s, (s == abort_src), ab);
        if (ab) begin
          aborted = 1;
          return;
        end
      end
    end
    while (!done && (lat < 2000)) begin
      @(negedge clock);
      #1;
      lat++;
    end
    check("done_seen", done, 1);
    if (run_en == '0) check("done_latency", lat, 3);
    check("busy_at_done", busy, 0);
    check("total_bytes", total_bytes, exp_total);
    check("err", err, exp_err);
    for (int s = 0; s < N_SRC; s++)
      if (run_en[s]) check("src_offset", src_offset[s*OFF_W +: OFF_W], exp_off[s]);
    check("beat_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("beat", obs_q[i], exp_q[i]);
    @(negedge clock);
    #1;
    check("done_pulse", done, 0);
    check("idle_after_done", dbg_state, IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ab;
    int b;
    repeat (3) @(negedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // All sources, free-flowing set_bit.
    load_t1();
    run_case(0, -1, ab);

    // Sparse enables with an alignment flush before source 2.
    clear_stim();
    add_chunk(0, 12);
    add_chunk(2, 12);
    add_chunk(4, 12);
    run_case(0, -1, ab);

    // Same traffic as the first run under 1,0,0,1 backpressure.
    load_t1();
    run_case(1, -1, ab);

    // Oversized chunk is clamped and flagged.
    load_t1();
    ch_bits[1][0] = BITS_W'(80);
    ch_val[1][0]  = {$urandom, $urandom};
    run_case(2, -1, ab);

    // Nothing enabled; also confirms err was cleared by this start.
    clear_stim();
    run_case(0, -1, ab);

    // Reset in the middle of source 1, then the same run again.
    load_t1();
    run_case(0, 1, ab);
    check("abort_reached", ab, 1);
    @(negedge clock);
    reset     = 1'b1;
    src_valid = '0;
    src_last  = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    run_case(0, -1, ab);

    // Random runs.
    for (int r = 0; r < 12; r++) begin
      clear_stim();
      for (int s = 0; s < N_SRC; s++) begin
        if ($urandom_range(0, 2) != 0) begin
          repeat ($urandom_range(1, 4)) begin
            case ($urandom_range(0, 11))
              0:       b = 0;
              1:       b = $urandom_range(65, 100);
              2:       b = 64;
              default: b = $urandom_range(1, 63);
            endcase
            add_chunk(s, b);
          end
        end
      end
      run_case($urandom_range(0, 2), -1, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
